ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage for the RV32 core. Captures the decoded instruction each cycle, resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, and drives the ALU's `SrcA`, `SrcB` and `Operation` inputs. It also detects load-use hazards and inserts one bubble while decode holds.

---
 rtl/ex_operand_stage_if.sv | 59 +++++
 rtl/ex_operand_stage.sv | 106 ++++++++++
 tb/tb_ex_operand_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between decode/forwarding logic and the ID/EX operand stage.
// The master side drives decode, pipeline-control and forwarding inputs; the slave side is the stage.
interface ex_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_alu_src;
    logic [OPCODE_LENGTH-1:0]  id_alu_op;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;

    logic                      stall;
    logic                      flush;

    logic                      exm_reg_write;
    logic [REG_ADDR_WIDTH-1:0] exm_rd;
    logic [DATA_WIDTH-1:0]     exm_result;
    logic                      wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [OPCODE_LENGTH-1:0]  Operation;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_valid;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;
    logic                      load_use_hazard;

    modport master (
        output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               stall, flush,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        input  SrcA, SrcB, Operation, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );

    modport slave (
        input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
               id_alu_src, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               stall, flush,
               exm_reg_write, exm_rd, exm_result, wb_reg_write, wb_rd, wb_data,
        output SrcA, SrcB, Operation, ex_store_data, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble insertion.
// Registered outputs appear one edge after capture; forwarding and the hazard flag are combinational.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    ex_operand_stage_if.slave  bus
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      alu_src;
        logic [OPCODE_LENGTH-1:0]  alu_op;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
    } ex_state_t;

    ex_state_t             ex_q;
    ex_state_t             ex_d;
    ex_state_t             id_instr;
    logic                  hazard;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    // EX/MEM beats MEM/WB; x0 is hard-wired zero and never takes a forwarded value.
    function automatic logic [DATA_WIDTH-1:0] forward(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic [DATA_WIDTH-1:0]     reg_data,
        input logic                      exm_we,
        input logic [REG_ADDR_WIDTH-1:0] exm_dst,
        input logic [DATA_WIDTH-1:0]     exm_val,
        input logic                      wb_we,
        input logic [REG_ADDR_WIDTH-1:0] wb_dst,
        input logic [DATA_WIDTH-1:0]     wb_val
    );
        if (rs == '0)                         return reg_data;
        else if (exm_we && (exm_dst == rs))   return exm_val;
        else if (wb_we && (wb_dst == rs))     return wb_val;
        else                                  return reg_data;
    endfunction

    always_comb begin
        id_instr           = '0;
        id_instr.valid     = bus.id_valid;
        id_instr.rs1_data  = bus.id_rs1_data;
        id_instr.rs2_data  = bus.id_rs2_data;
        id_instr.imm       = bus.id_imm;
        id_instr.rs1       = bus.id_rs1;
        id_instr.rs2       = bus.id_rs2;
        id_instr.rd        = bus.id_rd;
        id_instr.alu_src   = bus.id_alu_src;
        id_instr.alu_op    = bus.id_alu_op;
        id_instr.reg_write = bus.id_reg_write;
        id_instr.mem_read  = bus.id_mem_read;
        id_instr.mem_write = bus.id_mem_write;
    end

    // Conservative: rs2 is compared even for instructions that never read it.
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid &&
                    ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

    always_comb begin
        // NOTE: ex_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        ex_d = '0;
        if (bus.flush)                  ex_d = '0;
        else if (bus.stall)             ex_d = ex_q;
        else if (hazard)                ex_d = '0;
        else if (bus.id_valid)          ex_d = id_instr;
        else                            ex_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    always_comb begin
        fwd_rs1 = forward(ex_q.rs1, ex_q.rs1_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_data);
        fwd_rs2 = forward(ex_q.rs2, ex_q.rs2_data, bus.exm_reg_write, bus.exm_rd, bus.exm_result,
                          bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    end

    assign bus.SrcA            = fwd_rs1;
    assign bus.SrcB            = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign bus.ex_store_data   = fwd_rs2;
    assign bus.Operation       = ex_q.alu_op;
    assign bus.ex_rd           = ex_q.rd;
    assign bus.ex_valid        = ex_q.valid;
    assign bus.ex_reg_write    = ex_q.reg_write;
    assign bus.ex_mem_read     = ex_q.mem_read;
    assign bus.ex_mem_write    = ex_q.mem_write;
    assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed table, hand-written corner sequences,
// then randomized traffic compared against an instruction-level reference model.
module tb_ex_operand_stage;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id_valid;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alu_src;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        stall;
        logic        flush;
        logic        exm_we;
        logic [4:0]  exm_rd;
        logic [31:0] exm_result;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
    } drv_t;

    // Instruction currently held in EX, as the reference model sees it.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alu_src;
        logic [3:0]  op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } instr_t;

    typedef struct packed {
        drv_t        cap;
        drv_t        obs;
        logic [31:0] e_srca;
        logic [31:0] e_srcb;
        logic [31:0] e_store;
        logic [3:0]  e_op;
        logic [4:0]  e_rd;
        logic        e_valid;
    } row_t;

    drv_t   cur;
    instr_t m_ex;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input drv_t d);
        cur               = d;
        bus.id_valid      = d.id_valid;
        bus.id_rs1_data   = d.rs1_data;
        bus.id_rs2_data   = d.rs2_data;
        bus.id_imm        = d.imm;
        bus.id_rs1        = d.rs1;
        bus.id_rs2        = d.rs2;
        bus.id_rd         = d.rd;
        bus.id_alu_src    = d.alu_src;
        bus.id_alu_op     = d.alu_op;
        bus.id_reg_write  = d.reg_write;
        bus.id_mem_read   = d.mem_read;
        bus.id_mem_write  = d.mem_write;
        bus.stall         = d.stall;
        bus.flush         = d.flush;
        bus.exm_reg_write = d.exm_we;
        bus.exm_rd        = d.exm_rd;
        bus.exm_result    = d.exm_result;
        bus.wb_reg_write  = d.wb_we;
        bus.wb_rd         = d.wb_rd;
        bus.wb_data       = d.wb_data;
    endtask

    function automatic drv_t mk_id(input logic v, input logic [4:0] rs1, input logic [31:0] d1,
                                   input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                                   input logic src, input logic [3:0] op, input logic [4:0] rd);
        drv_t d = '0;
        d.id_valid  = v;
        d.rs1       = rs1;
        d.rs1_data  = d1;
        d.rs2       = rs2;
        d.rs2_data  = d2;
        d.imm       = imm;
        d.alu_src   = src;
        d.alu_op    = op;
        d.rd        = rd;
        d.reg_write = v;
        return d;
    endfunction

    function automatic drv_t mk_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                                    input logic ww, input logic [4:0] wrd, input logic [31:0] wdat);
        drv_t d = '0;
        d.exm_we     = ew;
        d.exm_rd     = erd;
        d.exm_result = eres;
        d.wb_we      = ww;
        d.wb_rd      = wrd;
        d.wb_data    = wdat;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] s, input logic [3:0] op, input logic [4:0] rd,
                             input logic v, input logic haz);
        check({tag, ".SrcA"},            bus.SrcA,            a);
        check({tag, ".SrcB"},            bus.SrcB,            b);
        check({tag, ".ex_store_data"},   bus.ex_store_data,   s);
        check({tag, ".Operation"},       32'(bus.Operation),  32'(op));
        check({tag, ".ex_rd"},           32'(bus.ex_rd),      32'(rd));
        check({tag, ".ex_valid"},        32'(bus.ex_valid),   32'(v));
        check({tag, ".load_use_hazard"}, 32'(bus.load_use_hazard), 32'(haz));
    endtask

    // Reference model: forwarding and hazard rules stated directly on the EX instruction.
    function automatic logic [31:0] m_operand(input logic [4:0] rs, input logic [31:0] data);
        if (rs != 5'd0 && cur.exm_we && cur.exm_rd == rs) return cur.exm_result;
        if (rs != 5'd0 && cur.wb_we && cur.wb_rd == rs)   return cur.wb_data;
        return data;
    endfunction

    function automatic logic m_hazard();
        return m_ex.valid && m_ex.mem_read && (m_ex.rd != 5'd0) && cur.id_valid &&
               ((m_ex.rd == cur.rs1) || (m_ex.rd == cur.rs2));
    endfunction

    function automatic instr_t to_instr(input drv_t d);
        instr_t i;
        i.valid     = 1'b1;
        i.rs1_data  = d.rs1_data;
        i.rs2_data  = d.rs2_data;
        i.imm       = d.imm;
        i.rs1       = d.rs1;
        i.rs2       = d.rs2;
        i.rd        = d.rd;
        i.alu_src   = d.alu_src;
        i.op        = d.alu_op;
        i.reg_write = d.reg_write;
        i.mem_read  = d.mem_read;
        i.mem_write = d.mem_write;
        return i;
    endfunction

    task automatic model_edge();
        if (cur.flush)               m_ex = '0;
        else if (cur.stall)          m_ex = m_ex;
        else if (m_hazard())         m_ex = '0;
        else if (cur.id_valid)       m_ex = to_instr(cur);
        else                         m_ex = '0;
    endtask

    task automatic check_model();
        logic [31:0] e_rs2;
        e_rs2 = m_operand(m_ex.rs2, m_ex.rs2_data);
        check_out("rnd", m_operand(m_ex.rs1, m_ex.rs1_data), m_ex.alu_src ? m_ex.imm : e_rs2,
                  e_rs2, m_ex.op, m_ex.rd, m_ex.valid, m_hazard());
        check("rnd.ex_reg_write", 32'(bus.ex_reg_write), 32'(m_ex.reg_write));
        check("rnd.ex_mem_read",  32'(bus.ex_mem_read),  32'(m_ex.mem_read));
        check("rnd.ex_mem_write", 32'(bus.ex_mem_write), 32'(m_ex.mem_write));
    endtask

    function automatic drv_t rand_drv();
        drv_t d = '0;
        d.id_valid   = ($urandom_range(0, 3) != 0);
        d.rs1        = 5'($urandom_range(0, 7));
        d.rs2        = 5'($urandom_range(0, 7));
        d.rd         = 5'($urandom_range(0, 7));
        d.rs1_data   = $urandom;
        d.rs2_data   = $urandom;
        d.imm        = $urandom;
        d.alu_src    = 1'($urandom_range(0, 1));
        d.alu_op     = 4'($urandom_range(0, 15));
        d.reg_write  = 1'($urandom_range(0, 1));
        d.mem_read   = ($urandom_range(0, 3) == 0);
        d.mem_write  = ($urandom_range(0, 3) == 0);
        d.stall      = ($urandom_range(0, 7) == 0);
        d.flush      = ($urandom_range(0, 9) == 0);
        d.exm_we     = 1'($urandom_range(0, 1));
        d.exm_rd     = 5'($urandom_range(0, 7));
        d.exm_result = $urandom;
        d.wb_we      = 1'($urandom_range(0, 1));
        d.wb_rd      = 5'($urandom_range(0, 7));
        d.wb_data    = $urandom;
        return d;
    endfunction

    initial begin
        row_t rows [8];
        drv_t lw, add, a, b, c;
        checks = 0;
        errors = 0;
        m_ex   = '0;

        // Reset held for three cycles while decode presents live data.
        reset = 1'b1;
        drive(mk_id(1, 5'd3, 32'hDEAD_BEEF, 5'd4, 32'h1234_5678, 32'h55, 1, 4'hF, 5'd9));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_out("reset", 0, 0, 0, 0, 0, 0, 0);
            check("reset.ex_reg_write", 32'(bus.ex_reg_write), 0);
            check("reset.ex_mem_read",  32'(bus.ex_mem_read),  0);
            check("reset.ex_mem_write", 32'(bus.ex_mem_write), 0);
        end
        reset = 1'b0;
        drive(mk_id(1, 5'd1, 32'h0000_0005, 5'd2, 32'h0, 32'h0, 0, 4'b0010, 5'd1));
        tick();
        drive('0);
        #1;
        check_out("first_capture", 32'h5, 32'h0, 32'h0, 4'b0010, 5'd1, 1, 0);
        tick();

        // Directed forwarding / operand-select table.
        rows[0] = '{mk_id(1, 3, 32'h11, 4, 32'h22, 0, 0, 2, 7), mk_fwd(1, 3, 32'hAA, 1, 3, 32'hBB),
                    32'hAA, 32'h22, 32'h22, 2, 7, 1};
        rows[1] = '{mk_id(1, 3, 32'h11, 4, 32'h22, 0, 0, 2, 7), mk_fwd(0, 3, 32'hAA, 1, 3, 32'hBB),
                    32'hBB, 32'h22, 32'h22, 2, 7, 1};
        rows[2] = '{mk_id(1, 0, 32'h0, 4, 32'h22, 0, 0, 2, 7), mk_fwd(1, 0, 32'hAA, 1, 0, 32'hBB),
                    32'h0, 32'h22, 32'h22, 2, 7, 1};
        rows[3] = '{mk_id(1, 1, 32'h50, 4, 32'h99, 32'hFFFF_FFFC, 1, 6, 9), mk_fwd(1, 4, 32'h1234, 1, 4, 32'h777),
                    32'h50, 32'hFFFF_FFFC, 32'h1234, 6, 9, 1};
        rows[4] = '{mk_id(1, 6, 32'h1, 9, 32'h2, 0, 0, 3, 10), mk_fwd(1, 6, 32'hC0FFEE, 1, 9, 32'hDEAD),
                    32'hC0FFEE, 32'hDEAD, 32'hDEAD, 3, 10, 1};
        rows[5] = '{mk_id(1, 6, 32'h44, 9, 32'h33, 0, 0, 3, 10), mk_fwd(0, 9, 32'h1, 0, 9, 32'h2),
                    32'h44, 32'h33, 32'h33, 3, 10, 1};
        rows[6] = '{mk_id(1, 12, 32'h5, 12, 32'h5, 0, 0, 8, 1), mk_fwd(1, 12, 32'h100, 1, 12, 32'h200),
                    32'h100, 32'h100, 32'h100, 8, 1, 1};
        rows[7] = '{mk_id(0, 3, 32'h11, 4, 32'h22, 32'h7, 1, 2, 7), mk_fwd(1, 3, 32'hAA, 1, 4, 32'hBB),
                    32'h0, 32'h0, 32'h0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive(rows[i].cap);
            tick();
            drive(rows[i].obs);
            #1;
            check_out($sformatf("table%0d", i), rows[i].e_srca, rows[i].e_srcb, rows[i].e_store,
                      rows[i].e_op, rows[i].e_rd, rows[i].e_valid, 0);
            tick();
        end

        // Load-use: one bubble, stall holding the hazard, then MEM/WB forward.
        lw = mk_id(1, 2, 32'h1000, 0, 32'h0, 32'h8, 1, 0, 5);
        lw.mem_read = 1'b1;
        add = mk_id(1, 5, 32'h0, 6, 32'h66, 0, 0, 0, 8);
        drive(lw);
        tick();
        a = add;
        a.stall = 1'b1;
        drive(a);
        #1;
        check("lu.hazard", 32'(bus.load_use_hazard), 1);
        tick();
        #1;
        check("lu.stall_hold_rd", 32'(bus.ex_rd), 5);
        check("lu.stall_hold_mr", 32'(bus.ex_mem_read), 1);
        check("lu.stall_hazard", 32'(bus.load_use_hazard), 1);
        drive(add);
        #1;
        check("lu.hazard_again", 32'(bus.load_use_hazard), 1);
        tick();
        a = add;
        a.exm_we = 1'b1;
        a.exm_rd = 5'd5;
        a.exm_result = 32'h1008;
        drive(a);
        #1;
        check("lu.bubble_valid", 32'(bus.ex_valid), 0);
        check("lu.bubble_hazard", 32'(bus.load_use_hazard), 0);
        tick();
        drive(mk_fwd(0, 0, 0, 1, 5, 32'hCAFE));
        #1;
        check_out("lu.captured", 32'hCAFE, 32'h66, 32'h66, 0, 8, 1, 0);
        tick();

        // Flush together with a load-use hazard gives a bubble.
        drive(lw);
        tick();
        a = add;
        a.flush = 1'b1;
        drive(a);
        #1;
        check("fh.hazard", 32'(bus.load_use_hazard), 1);
        tick();
        drive('0);
        #1;
        check_out("fh.bubble", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Stall for two edges with changing decode, then flush+stall.
        a = mk_id(1, 1, 32'h10, 2, 32'h20, 0, 0, 5, 3);
        b = mk_id(1, 7, 32'h77, 8, 32'h88, 0, 0, 9, 4);
        c = mk_id(1, 9, 32'h99, 10, 32'hAA, 32'h5, 1, 11, 6);
        b.stall = 1'b1;
        c.stall = 1'b1;
        drive(a);
        tick();
        drive(b);
        tick();
        drive(c);
        #1;
        check_out("stall2", 32'h10, 32'h20, 32'h20, 5, 3, 1, 0);
        tick();
        c.flush = 1'b1;
        drive(c);
        #1;
        check_out("stall3", 32'h10, 32'h20, 32'h20, 5, 3, 1, 0);
        tick();
        drive('0);
        #1;
        check_out("flush_stall", 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Back-to-back stream of four independent instructions.
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(mk_id(1, 20, 32'h100 + i, 21, 32'h200 + i, 0, 0, 4'(i + 1), 5'(10 + i)));
            else       drive('0);
            if (i > 0) begin
                #1;
                check_out($sformatf("b2b%0d", i - 1), 32'h100 + i - 1, 32'h200 + i - 1, 32'h200 + i - 1,
                          4'(i), 5'(9 + i), 1, 0);
            end
            tick();
        end

        // Asynchronous reset assertion mid-cycle clears the stage before any edge.
        drive(a);
        tick();
        drive('0);
        #1;
        check("async.pre_valid", 32'(bus.ex_valid), 1);
        reset = 1'b1;
        #1;
        check("async.valid", 32'(bus.ex_valid), 0);
        check("async.rd", 32'(bus.ex_rd), 0);
        check("async.srca", bus.SrcA, 0);
        tick();
        reset = 1'b0;
        m_ex = '0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(rand_drv());
            #1;
            check_model();
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
